// File: rtl/reg_file_mp_if.sv
// Register-file access bus: two write ports, two read ports with pending bits,
// a reserve port and the flattened debug view of every register.
interface reg_file_mp_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic                    WriteA;
    logic [ADDR_W-1:0]       SelectA;
    logic [WIDTH-1:0]        datainA;
    logic                    WriteB;
    logic [ADDR_W-1:0]       SelectB;
    logic [WIDTH-1:0]        datainB;
    logic [ADDR_W-1:0]       Aselect;
    logic [ADDR_W-1:0]       Bselect;
    logic [WIDTH-1:0]        Aoutput;
    logic [WIDTH-1:0]        Boutput;
    logic                    Apending;
    logic                    Bpending;
    logic                    Reserve;
    logic [ADDR_W-1:0]       Rselect;
    logic [DEPTH*WIDTH-1:0]  Rall;

    modport master (
        output WriteA, SelectA, datainA, WriteB, SelectB, datainB,
        output Aselect, Bselect, Reserve, Rselect,
        input  Aoutput, Boutput, Apending, Bpending, Rall
    );

    modport slave (
        input  WriteA, SelectA, datainA, WriteB, SelectB, datainB,
        input  Aselect, Bselect, Reserve, Rselect,
        output Aoutput, Boutput, Apending, Bpending, Rall
    );
endinterface

// File: rtl/reg_file_mp.sv
// Two-write/two-read register file with B-priority collisions, optional
// write-to-read forwarding, optional hard-wired zero register and pending bits.
module reg_file_mp #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic          Clock_50,
    input  logic          Clear_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            pending;
    logic [DEPTH-1:0]            pending_next;
    logic                        we_a;
    logic                        we_b;
    logic                        res_en;

    // Enables are gated by Clear_n so nothing is forwarded while in reset.
    assign we_a   = Clear_n && bus.WriteA  && !((ZERO_REG != 0) && (bus.SelectA == '0));
    assign we_b   = Clear_n && bus.WriteB  && !((ZERO_REG != 0) && (bus.SelectB == '0));
    assign res_en = Clear_n && bus.Reserve && !((ZERO_REG != 0) && (bus.Rselect == '0));

    always_comb begin
        pending_next = pending;
        if (we_a)
            pending_next[bus.SelectA] = 1'b0;
        if (we_b)
            pending_next[bus.SelectB] = 1'b0;
        if (res_en)
            pending_next[bus.Rselect] = 1'b1;
    end

    // Port B is written last so it overrides port A on an address collision.
    always_ff @(posedge Clock_50 or negedge Clear_n) begin
        if (!Clear_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            if (we_a)
                regs[bus.SelectA] <= bus.datainA;
            if (we_b)
                regs[bus.SelectB] <= bus.datainB;
            pending <= pending_next;
        end
    end

    always_comb begin
        bus.Aoutput  = regs[bus.Aselect];
        bus.Apending = pending[bus.Aselect];
        if ((ZERO_REG != 0) && (bus.Aselect == '0)) begin
            bus.Aoutput  = '0;
            bus.Apending = 1'b0;
        end else if ((BYPASS != 0) && we_b && (bus.SelectB == bus.Aselect)) begin
            bus.Aoutput  = bus.datainB;
            bus.Apending = 1'b0;
        end else if ((BYPASS != 0) && we_a && (bus.SelectA == bus.Aselect)) begin
            bus.Aoutput  = bus.datainA;
            bus.Apending = 1'b0;
        end
    end

    always_comb begin
        bus.Boutput  = regs[bus.Bselect];
        bus.Bpending = pending[bus.Bselect];
        if ((ZERO_REG != 0) && (bus.Bselect == '0)) begin
            bus.Boutput  = '0;
            bus.Bpending = 1'b0;
        end else if ((BYPASS != 0) && we_b && (bus.SelectB == bus.Bselect)) begin
            bus.Boutput  = bus.datainB;
            bus.Bpending = 1'b0;
        end else if ((BYPASS != 0) && we_a && (bus.SelectA == bus.Bselect)) begin
            bus.Boutput  = bus.datainA;
            bus.Bpending = 1'b0;
        end
    end

    // Debug view shows stored contents only, never forwarded data.
    assign bus.Rall = regs;
endmodule
